// File: rtl/block_mem_bridge_pkg.sv
// Shared definitions for the block/memory bridge.
// Holds the default geometry (word width, address width, block offset bits),
// the beats-per-block derivation and the FSM state enumeration.
// Imported as: import bridge_pkg::*;
package bridge_pkg;

    localparam int unsigned DefData  = 32;
    localparam int unsigned DefAddr  = 32;
    localparam int unsigned DefOfst  = 5;
    localparam int unsigned DefBlck  = 8 << DefOfst;
    localparam int unsigned DefBeats = DefBlck / DefData;

    // Number of memory words that make up one cache block.
    function automatic int unsigned beats_of(input int unsigned blck, input int unsigned data);
        return blck / data;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StDone
    } state_e;

endpackage

// File: rtl/block_mem_bridge_if.sv
// Word-wide memory port of the block/memory bridge.
// Signals:
//   mem_req   - beat request, held until a cycle with mem_ack
//   mem_we    - 1 for a write beat, 0 for a read beat
//   mem_addr  - byte address of the beat
//   mem_wdata - write data of the beat
//   mem_rdata - read data, valid with mem_ack
//   mem_ack   - beat acknowledge
// Modports: master (bridge side), slave (memory side).
interface block_mem_bridge_if
    import bridge_pkg::*;
#(
    parameter int unsigned DATA = DefData,
    parameter int unsigned ADDR = DefAddr
) ();

    logic            mem_req;
    logic            mem_we;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_wdata;
    logic [DATA-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/block_mem_bridge_beat_counter.sv
// Beat counter for block bursts.
// Counts acknowledged beats within a block and wraps to zero after the last one.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   inc_i   - advance by one beat (beat acknowledged)
//   count_o - current beat index
//   wrap_o  - the beat being acknowledged now is the last of the block
module beat_counter
    import bridge_pkg::*;
#(
    parameter int unsigned Beats = DefBeats
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     inc_i,
    output logic [$clog2(Beats)-1:0] count_o,
    output logic                     wrap_o
);

    localparam int unsigned Width = $clog2(Beats);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    assign wrap_o  = inc_i && (count_q == Width'(Beats - 1));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/block_mem_bridge.sv
// Block/memory bridge: converts single-cycle block fill and write-back
// strobes from a data cache into bursts of word beats on a memory port.
// Ports:
//   CLK, RESET      - clock, synchronous active-high reset
//   bread, bwrite   - one-cycle fill / write-back strobes (ignored while busy)
//   address         - request byte address, low OFST bits ignored
//   block_out       - write-back block, captured with bwrite
//   block_in        - assembled fill block
//   done            - one-cycle completion pulse
//   busy            - request in progress
//   mem             - memory port (block_mem_bridge_if.master)
// Build option: BLOCK_MEM_BRIDGE_POSTED_WR_EN -- when defined, a write-back
// reports done the cycle after capture and drains in the background.
module block_mem_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned DATA = DefData,
    parameter int unsigned ADDR = DefAddr,
    parameter int unsigned OFST = DefOfst,
    parameter int unsigned BLCK = 8 << OFST
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               bread,
    input  logic               bwrite,
    input  logic [ADDR-1:0]    address,
    input  logic [BLCK-1:0]    block_out,
    output logic [BLCK-1:0]    block_in,
    output logic               done,
    output logic               busy,
    block_mem_bridge_if.master mem
);

    localparam int unsigned BEATS = beats_of(BLCK, DATA);
    localparam int unsigned BeatW = $clog2(BEATS);
    localparam int unsigned BYTES = DATA / 8;

    state_e          state_q;
    logic [ADDR-1:0] base_q;
    logic [BLCK-1:0] wblk_q;
    logic [BLCK-1:0] rblk_q;
    logic            pend_q;
    logic            done_q;
    logic            busy_q;
    logic            mem_req_q;
    logic            mem_we_q;

    logic [BeatW-1:0] beat;
    logic             beat_inc;
    logic             beat_wrap;
    logic             in_burst;

    // Acks are only meaningful while a burst is running.
    assign in_burst = (state_q == StWr) || (state_q == StRd);
    assign beat_inc = in_burst && mem.mem_ack;

    beat_counter #(
        .Beats(BEATS)
    ) u_beat_counter (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .inc_i  (beat_inc),
        .count_o(beat),
        .wrap_o (beat_wrap)
    );

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = base_q + ADDR'(beat) * ADDR'(BYTES);
    assign mem.mem_wdata = wblk_q[32'(beat) * DATA +: DATA];

    assign block_in = rblk_q;
    assign done     = done_q;
    assign busy     = busy_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            base_q    <= '0;
            wblk_q    <= '0;
            rblk_q    <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bwrite) begin
                        base_q    <= {address[ADDR-1:OFST], {OFST{1'b0}}};
                        wblk_q    <= block_out;
                        // A simultaneous fill is replayed from the same base after the write.
                        pend_q    <= bread;
                        state_q   <= StWr;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef BLOCK_MEM_BRIDGE_POSTED_WR_EN
                        // With a fill pending, the single done pulse belongs to the fill.
                        done_q    <= !bread;
`endif
                    end else if (bread) begin
                        base_q    <= {address[ADDR-1:OFST], {OFST{1'b0}}};
                        state_q   <= StRd;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                StWr, StRd: begin
                    if (state_q == StRd && mem.mem_ack) begin
                        rblk_q[32'(beat) * DATA +: DATA] <= mem.mem_rdata;
                    end
                    if (beat_wrap) begin
                        mem_we_q <= 1'b0;
                        if (pend_q) begin
                            pend_q  <= 1'b0;
                            state_q <= StRd;
                        end else begin
                            mem_req_q <= 1'b0;
`ifdef BLOCK_MEM_BRIDGE_POSTED_WR_EN
                            if (state_q == StWr) begin
                                // Done was already reported at capture.
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= StDone;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/block_mem_bridge.md
BLOCK_MEM_BRIDGE -- requirements
Module: block_mem_bridge

Interface
REQ-001 Parameter DATA, 32, memory word width in bits SHALL be provided.
REQ-002 Parameter ADDR, 32, byte-address width SHALL be provided.
REQ-003 Parameter OFST, 5, log2 block size in bytes SHALL be provided.
REQ-004 Parameter BLCK, 8<<OFST (256), cache block width in bits SHALL be provided; BEATS = BLCK/DATA (8).
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 bread  input  1  one-cycle strobe from the data cache requesting a block fill.
REQ-008 bwrite  input  1  one-cycle strobe from the data cache requesting a block write-back.
REQ-009 address  input  ADDR  byte address of the request; low OFST bits ignored.
REQ-010 block_out  input  BLCK  write-back block from the cache, valid with bwrite.
REQ-011 block_in  output  BLCK  assembled fill block for the cache.
REQ-012 done  output  1  one-cycle pulse: block_in valid (fill) or write-back complete.
REQ-013 busy  output  1  high whenever state is not IDLE or a request is pending.
REQ-014 mem_req, mem_we  output  1 each  memory beat request and write-enable.
REQ-015 mem_addr  output  ADDR; mem_wdata  output  DATA  beat address and write data.
REQ-016 mem_rdata  input  DATA; mem_ack  input  1  beat read data and beat acknowledge.

Function
REQ-017 FSM states SHALL be IDLE, WR, RD, DONE.
REQ-018 In IDLE, bread or bwrite SHALL capture base = address with low OFST bits cleared; bwrite also captures block_out.
REQ-019 bwrite SHALL take priority over a simultaneous bread; the bread SHALL be held pending and serviced right after the write-back, using the same base.
REQ-020 Strobes arriving while busy SHALL be ignored.
REQ-021 In WR/RD, mem_req SHALL stay high until a cycle with mem_ack; beat counter increments on each ack.
REQ-022 mem_addr SHALL equal base + beat*(DATA/8); mem_we = 1 in WR, 0 in RD.
REQ-023 mem_wdata SHALL be block_out[beat*DATA +: DATA] (beat 0 = least-significant word).
REQ-024 In RD, mem_rdata on ack SHALL be written to block_in[beat*DATA +: DATA]; other words hold.
REQ-025 On the ack of beat BEATS-1, the counter SHALL wrap to 0 and the FSM enter DONE (or RD if a bread is pending).
REQ-026 DONE SHALL last exactly one cycle with done = 1, then IDLE; busy low in the following IDLE cycle.
REQ-027 Minimum latency, strobe to done, with mem_ack tied high: BEATS+1 cycles.
REQ-028 mem_req SHALL be 0 in IDLE and DONE; mem_ack outside WR/RD SHALL be ignored.

Reset
REQ-029 RESET SHALL force IDLE, beat = 0, pending cleared, done = busy = mem_req = mem_we = 0, block_in = 0, mem_addr = mem_wdata = 0.
REQ-030 RESET mid-burst SHALL abort: mem_req low the next cycle, no done pulse, block_in cleared.

Configuration
REQ-031 Macro BLOCK_MEM_BRIDGE_POSTED_WR_EN defined: write-back done SHALL pulse the cycle after capture; the burst drains in background; busy stays high until drain ends; a pending bread waits for the drain.
REQ-032 Macro undefined: write-back done SHALL pulse only after the last write beat (REQ-025/026).

Structure
REQ-033 Package bridge_pkg SHALL hold default DATA/ADDR/OFST, BEATS derivation and the state enumeration.
REQ-034 Sub-module beat_counter (log2 BEATS bits, increment-on-ack, wrap flag) SHALL be instantiated once.

Verification
REQ-035 bread, address 0x0000_1234, mem_ack tied 1, mem_rdata = 0x100+beat -> mem_addr 0x1220..0x123C, done at cycle 9, block_in words 0x100..0x107.
REQ-036 bwrite, address 0x40, block_out word i = 0xA0+i -> 8 beats, mem_we 1, mem_wdata 0xA0..0xA7, addresses 0x40..0x5C, one done pulse.
REQ-037 bread and bwrite same cycle, address 0x80 -> 8 write beats, then 8 read beats from 0x80, exactly one done, after the read.
REQ-038 mem_ack low 3 cycles per beat -> mem_req and mem_addr held stable while waiting, done at cycle 33.
REQ-039 RESET asserted at beat 4 of a read -> mem_req 0 next cycle, no done, block_in 0, fresh bread completes normally.
REQ-040 Posted mode, bwrite at cycle 0 -> done at cycle 1, busy high through cycle 8, bread at cycle 2 ignored.
